// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STATS_EN to add saturating stall/bubble statistics counters.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic              ready_reg;
  logic              valid_reg;
  logic [1:0]        occ_reg;

  logic in_fire;
  logic out_fire;

  // ready_reg is a flop so out_ready_i never reaches in_ready_o combinationally
  assign in_fire  = in_valid_i & ready_reg;
  assign out_fire = valid_reg & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= EMPTY;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
      ready_reg     <= 1'b1;
      valid_reg     <= 1'b0;
      occ_reg       <= 2'd0;
    end else if (flush_i) begin
      // Data registers are left alone; only control is scrubbed.
      state_reg     <= EMPTY;
      main_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
      ready_reg     <= 1'b1;
      valid_reg     <= 1'b0;
      occ_reg       <= 2'd0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl_reg <= in_ctrl_i;
            main_data_reg <= in_data_i;
            state_reg     <= FULL;
            valid_reg     <= 1'b1;
            occ_reg       <= 2'd1;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_reg <= in_ctrl_i;
            main_data_reg <= in_data_i;
          end else if (out_fire) begin
            state_reg <= EMPTY;
            valid_reg <= 1'b0;
            occ_reg   <= 2'd0;
          end else if (in_fire) begin
            skid_ctrl_reg <= in_ctrl_i;
            skid_data_reg <= in_data_i;
            state_reg     <= SKID;
            ready_reg     <= 1'b0;
            occ_reg       <= 2'd2;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_ctrl_reg <= skid_ctrl_reg;
            main_data_reg <= skid_data_reg;
            state_reg     <= FULL;
            ready_reg     <= 1'b1;
            occ_reg       <= 2'd1;
          end
        end
        default: begin
          state_reg <= EMPTY;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          occ_reg   <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready_o  = ready_reg;
  assign out_valid_o = valid_reg;
  assign out_ctrl_o  = valid_reg ? main_ctrl_reg : '0;
  assign out_data_o  = main_data_reg;
  assign occupancy_o = occ_reg;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  // Saturating counters; flush deliberately has no effect on them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (valid_reg && !out_ready_i && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (!valid_reg && (bubble_cnt_reg != '1))
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt_o  = stall_cnt_reg;
  assign bubble_cnt_o = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a randomized
// run against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_buf;

  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: FIFO contents, value shown on out_data when idle, counters
  entry_t            q[$];
  logic [DATA_W-1:0] stale_m;
  int                stall_m;
  int                bubble_m;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
    .occupancy_o (occupancy)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt_o (stall_cnt),
    .bubble_cnt_o(bubble_cnt)
`endif
  );

  // One clock edge with the current inputs; advances the model alongside.
  task automatic tick;
    bit m_ready, m_valid, in_f, out_f;
    m_ready = (q.size() < 2);
    m_valid = (q.size() > 0);
    in_f    = in_valid && m_ready;
    out_f   = m_valid && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      stale_m  = '0;
      stall_m  = 0;
      bubble_m = 0;
    end else begin
      if (m_valid && !out_ready && stall_m != CNT_MAX) stall_m++;
      if (!m_valid && bubble_m != CNT_MAX) bubble_m++;
      if (flush) begin
        if (q.size() > 0) stale_m = q[0].data;
        q.delete();
      end else begin
        if (out_f) begin
          stale_m = q[0].data;
          void'(q.pop_front());
        end
        if (in_f) q.push_back({in_ctrl, in_data});
        if (q.size() > 0) stale_m = q[0].data;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_ctrl, out_data, in_ready, occupancy} !== {1'b0, 8'h00, 32'h0, 1'b1, 2'd0}) begin
      n_fails++;
      $display("FAIL reset: valid=%b ctrl=%h data=%h ready=%b occ=%0d, required 0/00/00000000/1/0",
               out_valid, out_ctrl, out_data, in_ready, occupancy);
    end
    $display("reset: valid=%b ctrl=%h data=%h ready=%b occ=%0d", out_valid, out_ctrl, out_data, in_ready, occupancy);
    rst = 1'b0;
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 32'(i);
      tick();
      n_checks++;
      if ({out_valid, out_ctrl, out_data, occupancy, in_ready} !== {1'b1, 8'hA5, 32'(i), 2'd1, 1'b1}) begin
        n_fails++;
        $display("FAIL stream[%0d]: valid=%b ctrl=%h data=%h occ=%0d ready=%b, required 1/a5/%h/1/1",
                 i, out_valid, out_ctrl, out_data, occupancy, in_ready, 32'(i));
      end
      $display("stream: in %h -> out valid=%b data=%h occ=%0d", 32'(i), out_valid, out_data, occupancy);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    logic [DATA_W-1:0] exp_seq [3];
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A;
    in_data = 32'h11;
    tick();
    n_checks++;
    if ({occupancy, in_ready} !== {2'd1, 1'b1}) begin
      n_fails++;
      $display("FAIL bp_first: occ=%0d ready=%b, required 1/1", occupancy, in_ready);
    end
    in_data = 32'h22;
    tick();
    n_checks++;
    if ({occupancy, in_ready, out_data} !== {2'd2, 1'b0, 32'h11}) begin
      n_fails++;
      $display("FAIL bp_skid: occ=%0d ready=%b data=%h, required 2/0/00000011", occupancy, in_ready, out_data);
    end
    in_data = 32'h33;
    tick();
    n_checks++;
    if ({occupancy, in_ready, out_data} !== {2'd2, 1'b0, 32'h11}) begin
      n_fails++;
      $display("FAIL bp_hold: occ=%0d ready=%b data=%h, required 2/0/00000011", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      tick();
      if (k == 2) in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, exp_seq[k]}) begin
        n_fails++;
        $display("FAIL bp_drain[%0d]: valid=%b data=%h, required 1/%h", k, out_valid, out_data, exp_seq[k]);
      end
      $display("backpressure: drain out valid=%b data=%h occ=%0d", out_valid, out_data, occupancy);
    end
    tick();
    n_checks++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      n_fails++;
      $display("FAIL bp_empty: valid=%b occ=%0d, required 0/0 (duplicate?)", out_valid, occupancy);
    end
  endtask

  task automatic test_bubble;
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_ctrl, out_data} !== {1'b0, 8'h00, 32'hDEADBEEF}) begin
      n_fails++;
      $display("FAIL bubble: valid=%b ctrl=%h data=%h, required 0/00/deadbeef", out_valid, out_ctrl, out_data);
    end
    $display("bubble: valid=%b ctrl=%h data=%h", out_valid, out_ctrl, out_data);
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h3C;
    in_data = 32'hA0A0; tick();
    in_data = 32'hB0B0; tick();
    flush = 1'b1; in_data = 32'hC0C0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({occupancy, out_valid, out_ctrl, in_ready, out_data} !== {2'd0, 1'b0, 8'h00, 1'b1, 32'hA0A0}) begin
      n_fails++;
      $display("FAIL flush: occ=%0d valid=%b ctrl=%h ready=%b data=%h, required 0/0/00/1/0000a0a0",
               occupancy, out_valid, out_ctrl, in_ready, out_data);
    end
    $display("flush: occ=%0d valid=%b ctrl=%h ready=%b", occupancy, out_valid, out_ctrl, in_ready);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fails++;
        $display("FAIL flush_ghost[%0d]: valid=%b data=%h, required valid 0", k, out_valid, out_data);
      end
    end
    in_valid = 1'b1; in_ctrl = 8'h01; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h01, 32'h55}) begin
      n_fails++;
      $display("FAIL flush_after: valid=%b ctrl=%h data=%h, required 1/01/00000055", out_valid, out_ctrl, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h7E;
    in_data = 32'h1234; tick();
    in_data = 32'h5678; tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({out_valid, out_ctrl, out_data, in_ready, occupancy} !== {1'b0, 8'h00, 32'h0, 1'b1, 2'd0}) begin
      n_fails++;
      $display("FAIL reset_mid: valid=%b ctrl=%h data=%h ready=%b occ=%0d, required 0/00/00000000/1/0",
               out_valid, out_ctrl, out_data, in_ready, occupancy);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h11; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data, occupancy} !== {1'b1, 32'h77, 2'd1}) begin
      n_fails++;
      $display("FAIL reset_first: valid=%b data=%h occ=%0d, required 1/00000077/1", out_valid, out_data, occupancy);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_alone: valid=%b data=%h, required valid 0", out_valid, out_data);
    end
    $display("reset_mid: post-reset entry %h emerged alone", 32'h77);
  endtask

  task automatic test_random;
    int errs_before;
    errs_before = n_fails;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Payload must stay put while offered and not yet accepted
      if (!(in_valid && q.size() >= 2)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_ctrl  = CTRL_W'($urandom);
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
      n_checks++;
      if (out_valid !== (q.size() > 0)) begin
        n_fails++;
        $display("FAIL rnd_valid cyc %0d: got %b, required %b", cyc, out_valid, q.size() > 0);
      end
      n_checks++;
      if (in_ready !== (q.size() < 2)) begin
        n_fails++;
        $display("FAIL rnd_ready cyc %0d: got %b, required %b", cyc, in_ready, q.size() < 2);
      end
      n_checks++;
      if (occupancy !== 2'(q.size())) begin
        n_fails++;
        $display("FAIL rnd_occ cyc %0d: got %0d, required %0d", cyc, occupancy, q.size());
      end
      n_checks++;
      if (out_ctrl !== ((q.size() > 0) ? q[0].ctrl : 8'h00)) begin
        n_fails++;
        $display("FAIL rnd_ctrl cyc %0d: got %h, required %h", cyc, out_ctrl, (q.size() > 0) ? q[0].ctrl : 8'h00);
      end
      n_checks++;
      if (out_data !== ((q.size() > 0) ? q[0].data : stale_m)) begin
        n_fails++;
        $display("FAIL rnd_data cyc %0d: got %h, required %h", cyc, out_data, (q.size() > 0) ? q[0].data : stale_m);
      end
`ifdef PIPE_STATS_EN
      n_checks++;
      if ({stall_cnt, bubble_cnt} !== {CNT_W'(stall_m), CNT_W'(bubble_m)}) begin
        n_fails++;
        $display("FAIL rnd_stats cyc %0d: stall=%0d bubble=%0d, required %0d/%0d", cyc, stall_cnt, bubble_cnt, stall_m, bubble_m);
      end
`endif
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    $display("random: 400 cycles, %0d new failures", n_fails - errs_before);
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats;
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h42; in_data = 32'h9;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if (stall_cnt !== CNT_W'(CNT_MAX)) begin
      n_fails++;
      $display("FAIL stall_sat: got %0d, required %0d", stall_cnt, CNT_MAX);
    end
    $display("stats: stall_cnt=%0d after 20 stalled cycles", stall_cnt);
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (bubble_cnt !== CNT_W'(3)) begin
      n_fails++;
      $display("FAIL bubble_cnt: got %0d, required 3", bubble_cnt);
    end
    $display("stats: bubble_cnt=%0d after 3 idle cycles", bubble_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
